wb_forward_stage: RTL

- Write-back end of the pipeline: consumes execute-memory results and drives the register-file write.
- Returns forwarding data and forward selects to the execute-memory stage.
- Holds the EX/M→WB pipeline buffer, the write-back data mux, the WB→EX forwarding comparators and a retired-instruction counter.
- Stall and flush controls come from the hazard/branch logic.

---
 rtl/wb_forward_stage_if.sv | 48 ++++
 rtl/wb_forward_stage.sv | 81 ++++++++
 2 files changed

// File: rtl/wb_forward_stage_if.sv
// Bus between the execute-memory stage and the write-back stage: pipeline controls, EX/M result fields,
// EX/M source registers for forwarding, and the register-file write / forwarding returns.
interface wb_forward_stage_if #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3,
   parameter int COUNT_W = 32
);
   logic               i_stall;
   logic               i_flush;
   logic [1:0]         i_wb_selector;
   logic               i_write_back;
   logic [ADDR_W-1:0]  i_write_addr;
   logic [DATA_W-1:0]  i_ex_result;
   logic [DATA_W-1:0]  i_memory_data;
   logic [DATA_W-1:0]  i_immediate;
   logic [DATA_W-1:0]  i_input_port;
   logic [ADDR_W-1:0]  i_ex_rs1;
   logic [ADDR_W-1:0]  i_ex_rs2;
   logic               i_ex_rs1_used;
   logic               i_ex_rs2_used;

   logic               o_rf_write_en;
   logic [ADDR_W-1:0]  o_rf_write_addr;
   logic [DATA_W-1:0]  o_rf_write_data;
   logic [DATA_W-1:0]  o_data_wb;
   logic               o_data1_forward;
   logic               o_data2_forward;
   logic               o_valid;
   logic [COUNT_W-1:0] o_retired_count;

   // EX/M side (and hazard/branch control)
   modport master (
      output i_stall, i_flush, i_wb_selector, i_write_back, i_write_addr,
             i_ex_result, i_memory_data, i_immediate, i_input_port,
             i_ex_rs1, i_ex_rs2, i_ex_rs1_used, i_ex_rs2_used,
      input  o_rf_write_en, o_rf_write_addr, o_rf_write_data, o_data_wb,
             o_data1_forward, o_data2_forward, o_valid, o_retired_count
   );

   // write-back stage side
   modport slave (
      input  i_stall, i_flush, i_wb_selector, i_write_back, i_write_addr,
             i_ex_result, i_memory_data, i_immediate, i_input_port,
             i_ex_rs1, i_ex_rs2, i_ex_rs1_used, i_ex_rs2_used,
      output o_rf_write_en, o_rf_write_addr, o_rf_write_data, o_data_wb,
             o_data1_forward, o_data2_forward, o_valid, o_retired_count
   );
endinterface

// File: rtl/wb_forward_stage.sv
// Write-back stage: EX/M->WB buffer, write-back source mux, WB->EX forward selects, retire counter.
// One cycle from EX/M capture to register-file write; stall holds the buffer, flush (dominant) inserts a bubble.
module wb_forward_stage #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3,
   parameter int COUNT_W = 32
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   wb_forward_stage_if.slave    bus
);

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_MEM  = 2'b01;
   localparam logic [1:0] SEL_IMM  = 2'b10;

   typedef struct packed {
      logic              valid;
      logic              write_back;
      logic [ADDR_W-1:0] write_addr;
      logic [1:0]        wb_selector;
      logic [DATA_W-1:0] ex_result;
      logic [DATA_W-1:0] memory_data;
      logic [DATA_W-1:0] immediate;
      logic [DATA_W-1:0] input_port;
   } wb_buf_t;

   wb_buf_t            wb_q;
   logic [COUNT_W-1:0] retired_q;
   logic [DATA_W-1:0]  wb_data;
   logic               wr_live;
   logic               retire;

   // An occupied slot leaves on any non-stalled edge, or when flushed out from under a stall.
   assign retire = wb_q.valid & (~bus.i_stall | bus.i_flush);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wb_q      <= '0;
         retired_q <= '0;
      end else begin
         if (retire)
            retired_q <= retired_q + COUNT_W'(1);
         if (bus.i_flush) begin
            wb_q <= '0;
         end else if (!bus.i_stall) begin
            wb_q.valid       <= 1'b1;
            wb_q.write_back  <= bus.i_write_back;
            wb_q.write_addr  <= bus.i_write_addr;
            wb_q.wb_selector <= bus.i_wb_selector;
            wb_q.ex_result   <= bus.i_ex_result;
            wb_q.memory_data <= bus.i_memory_data;
            wb_q.immediate   <= bus.i_immediate;
            wb_q.input_port  <= bus.i_input_port;
         end
      end
   end

   always_comb begin
      wb_data = wb_q.input_port;
      case (wb_q.wb_selector)
         SEL_ALU: wb_data = wb_q.ex_result;
         SEL_MEM: wb_data = wb_q.memory_data;
         SEL_IMM: wb_data = wb_q.immediate;
         default: wb_data = wb_q.input_port;
      endcase
   end

   assign wr_live = wb_q.valid & wb_q.write_back;

   assign bus.o_rf_write_en   = wr_live;
   assign bus.o_rf_write_addr = wb_q.write_addr;
   assign bus.o_rf_write_data = wb_data;
   assign bus.o_data_wb       = wb_data;
   assign bus.o_valid         = wb_q.valid;
   assign bus.o_retired_count = retired_q;

   assign bus.o_data1_forward = wr_live & bus.i_ex_rs1_used & (bus.i_ex_rs1 == wb_q.write_addr);
   assign bus.o_data2_forward = wr_live & bus.i_ex_rs2_used & (bus.i_ex_rs2 == wb_q.write_addr);

endmodule
